// File: rtl/level_alarm_controller.sv
// Tank level supervisor: hysteresis fill-pump control with overflow/underflow alarms
// and a fault state. Every non-fault state change needs CONFIRM_SAMPLES consecutive samples.
//
// state  | meaning
// NORMAL | level between thresholds, pump off
// LOW    | filling, pump on, underflow indicated
// HIGH   | overflow alarm, alarm_led blinking
// FAULT  | bad level or thresholds seen, alarm_led blinking
module level_alarm_controller #(
  parameter int CONFIRM_SAMPLES = 4,
  parameter int BLINK_CYCLES    = 50_000_000,
  parameter int LEVEL_MAX       = 100
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] level,
  input  logic [7:0] high_threshold,
  input  logic [7:0] low_threshold,
  output logic       pump_on,
  output logic       overflow_alarm,
  output logic       underflow,
  output logic       fault,
  output logic       alarm_led,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [7:0]    LVL_MAX    = 8'(LEVEL_MAX);
  localparam logic [3:0]    CONFIRM    = 4'(CONFIRM_SAMPLES);

  state_t          state_q, state_d;
  state_t          cand_q, cand_d;
  state_t          target;
  logic [3:0]      cnt_q, cnt_d, cnt_inc, cnt_next;
  logic [BW-1:0]   blink_q, blink_d;
  logic            led_q, led_d;
  logic            bad, qual;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= NORMAL;
      cand_q  <= NORMAL;
      cnt_q   <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    target   = NORMAL;
    qual     = 1'b0;
    cnt_next = '0;
    cnt_inc  = (cnt_q == CONFIRM) ? cnt_q : cnt_q + 4'd1;
    bad      = (level > LVL_MAX) || (high_threshold > LVL_MAX) ||
               (high_threshold <= low_threshold);

    if (sample_valid) begin
      if (bad) begin
        state_d = FAULT;
        cnt_d   = '0;
        cand_d  = NORMAL;
      end else begin
        unique case (state_q)
          NORMAL: begin
            if (level <= low_threshold) begin
              qual   = 1'b1;
              target = LOW;
            end else if (level > high_threshold) begin
              qual   = 1'b1;
              target = HIGH;
            end
          end
          LOW:   qual = (level >= high_threshold);
          HIGH:  qual = (level < high_threshold);
          FAULT: qual = 1'b1;
        endcase

        if (!qual) begin
          cnt_d  = '0;
          cand_d = NORMAL;
        end else begin
          // A switch of candidate direction in NORMAL starts a fresh streak.
          cnt_next = (state_q == NORMAL && target != cand_q) ? 4'd1 : cnt_inc;
          if (cnt_next >= CONFIRM) begin
            state_d = target;
            cnt_d   = '0;
            cand_d  = NORMAL;
          end else begin
            cnt_d  = cnt_next;
            cand_d = target;
          end
        end
      end
    end
  end

  // Blink phase restarts on every state change so the first toggle lands
  // BLINK_CYCLES after entry.
  always_comb begin
    blink_d = '0;
    led_d   = 1'b0;
    if (state_d == state_q && (state_q == HIGH || state_q == FAULT)) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        led_d   = ~led_q;
      end else begin
        blink_d = blink_q + 1'b1;
        led_d   = led_q;
      end
    end
  end

  assign state          = state_q;
  assign pump_on        = (state_q == LOW);
  assign underflow      = (state_q == LOW);
  assign overflow_alarm = (state_q == HIGH);
  assign fault          = (state_q == FAULT);
  assign alarm_led      = led_q;

endmodule

// File: tb/tb_level_alarm_controller.sv
// Bench for level_alarm_controller: directed test-plan steps then random samples,
// every cycle compared against a streak-counting reference model.
module tb_level_alarm_controller;
  localparam int C = 4;
  localparam int B = 8;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] level = 8'd0;
  logic [7:0] high_threshold = 8'd75;
  logic [7:0] low_threshold = 8'd25;
  logic       pump_on, overflow_alarm, underflow, fault, alarm_led;
  logic [1:0] state;

  always #5 clk_100MHz = ~clk_100MHz;

  level_alarm_controller #(
    .CONFIRM_SAMPLES(C),
    .BLINK_CYCLES(B),
    .LEVEL_MAX(100)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .sample_valid(sample_valid),
    .level(level),
    .high_threshold(high_threshold),
    .low_threshold(low_threshold),
    .pump_on(pump_on),
    .overflow_alarm(overflow_alarm),
    .underflow(underflow),
    .fault(fault),
    .alarm_led(alarm_led),
    .state(state)
  );

  int errors = 0;
  int checks = 0;

  // Model: state 0..3, length of current qualifying streak, its target (-1 none),
  // and cycles spent in the current state (blink phase follows from that).
  int m_state = 0;
  int m_cnt   = 0;
  int m_cand  = -1;
  int m_age   = 0;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(bit rst, bit v, int lvl, int hi, int lo);
    int prev;
    int tgt;
    prev = m_state;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_cand = -1; m_age = 0;
      return;
    end
    if (v) begin
      if (lvl > 100 || hi > 100 || hi <= lo) begin
        m_state = 3; m_cnt = 0; m_cand = -1;
      end else begin
        tgt = -1;
        case (m_state)
          0: tgt = (lvl <= lo) ? 1 : ((lvl > hi) ? 2 : -1);
          1: tgt = (lvl >= hi) ? 0 : -1;
          2: tgt = (lvl < hi) ? 0 : -1;
          default: tgt = 0;
        endcase
        if (tgt < 0) begin
          m_cnt = 0; m_cand = -1;
        end else begin
          m_cnt  = (tgt == m_cand) ? m_cnt + 1 : 1;
          m_cand = tgt;
          if (m_cnt >= C) begin
            m_state = tgt; m_cnt = 0; m_cand = -1;
          end
        end
      end
    end
    if (m_state != prev) m_age = 0;
    else m_age++;
  endfunction

  task automatic cyc(bit v, int lvl, int hi = 75, int lo = 25, bit rst = 1'b0);
    logic [7:0] exp_v;
    logic       led_e;
    sample_valid   = v;
    level          = 8'(lvl);
    high_threshold = 8'(hi);
    low_threshold  = 8'(lo);
    reset          = rst;
    @(posedge clk_100MHz);
    #1;
    sample_valid = 1'b0;
    reset        = 1'b0;
    model_edge(rst, v, lvl, hi, lo);
    led_e = (m_state >= 2) ? 1'((m_age / B) % 2) : 1'b0;
    exp_v = {1'b0, 2'(m_state), 1'(m_state == 1), 1'(m_state == 2),
             1'(m_state == 1), 1'(m_state == 3), led_e};
    check("outputs{state,pump,ovf,udf,fault,led}",
          {1'b0, state, pump_on, overflow_alarm, underflow, fault, alarm_led}, exp_v);
  endtask

  task automatic expect_state(string tag, int exp);
    check(tag, {6'd0, state}, 8'(exp));
  endtask

  initial begin
    int seq2[10] = '{50, 50, 76, 76, 76, 40, 76, 76, 76, 76};
    int seq4[7]  = '{20, 20, 90, 20, 20, 20, 20};
    int regime;
    int lvl, hi, lo;
    bit v, r;

    cyc(0, 0, 75, 25, 1);
    check("reset_outputs", {3'd0, pump_on, overflow_alarm, underflow, fault, alarm_led}, 8'd0);
    expect_state("reset_state", 0);

    // NORMAL -> LOW after 4 samples, not after 3
    repeat (3) cyc(1, 20);
    cyc(0, 0);
    expect_state("low_after3", 0);
    cyc(1, 20);
    expect_state("low_after4", 1);
    check("pump_on_low", {7'd0, pump_on}, 8'd1);

    // LOW -> NORMAL; the 40 breaks the streak
    for (int i = 0; i < 9; i++) cyc(1, seq2[i]);
    expect_state("low_hold_before_last", 1);
    cyc(1, seq2[9]);
    expect_state("low_to_normal", 0);
    check("pump_off_normal", {7'd0, pump_on}, 8'd0);

    // NORMAL -> HIGH, blink timing, then back
    repeat (4) cyc(1, 90);
    expect_state("high_entry", 2);
    repeat (7) cyc(0, 0);
    check("led_before_first_toggle", {7'd0, alarm_led}, 8'd0);
    cyc(0, 0);
    check("led_first_toggle", {7'd0, alarm_led}, 8'd1);
    repeat (8) cyc(0, 0);
    check("led_second_toggle", {7'd0, alarm_led}, 8'd0);
    repeat (5) cyc(0, 0);
    repeat (4) cyc(1, 70);
    expect_state("high_to_normal", 0);
    check("led_cleared", {7'd0, alarm_led}, 8'd0);

    // candidate switch restarts the streak
    for (int i = 0; i < 6; i++) cyc(1, seq4[i]);
    expect_state("cand_switch_no_low", 0);
    cyc(1, seq4[6]);
    expect_state("cand_switch_low", 1);

    // bad level from LOW, recovery, bad thresholds from HIGH
    cyc(1, 120);
    expect_state("fault_level", 3);
    check("fault_pump_off", {6'd0, fault, pump_on}, 8'b10);
    repeat (3) cyc(1, 50);
    expect_state("fault_hold", 3);
    cyc(1, 50);
    expect_state("fault_recover", 0);
    repeat (4) cyc(1, 90);
    repeat (3) cyc(0, 0);
    cyc(1, 50, 30, 30);
    expect_state("fault_thresholds", 3);
    repeat (10) cyc(0, 0);
    repeat (4) cyc(1, 50);
    expect_state("fault_recover2", 0);

    // reset mid-confirmation in LOW
    repeat (4) cyc(1, 20);
    cyc(1, 80);
    cyc(1, 80);
    cyc(0, 0, 75, 25, 1);
    check("reset_mid_outputs", {3'd0, pump_on, overflow_alarm, underflow, fault, alarm_led}, 8'd0);
    expect_state("reset_mid_state", 0);
    repeat (3) cyc(1, 20);
    expect_state("reset_mid_no_low", 0);

    // random samples, threshold changes and occasional resets
    regime = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 12 == 0) begin
        case ($urandom_range(0, 2))
          0: regime = 10;
          1: regime = 50;
          default: regime = 92;
        endcase
      end
      v   = ($urandom_range(0, 3) != 0);
      lvl = regime + int'($urandom_range(0, 10)) - 5;
      if ($urandom_range(0, 19) == 0) lvl = int'($urandom_range(0, 130));
      hi = 75; lo = 25;
      case ($urandom_range(0, 15))
        0: begin hi = int'($urandom_range(0, 110)); lo = int'($urandom_range(0, 110)); end
        1, 2, 3: begin hi = 60; lo = 40; end
        default: ;
      endcase
      r = ($urandom_range(0, 63) == 0);
      cyc(v, lvl, hi, lo, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_alarm_controller.md
Name: level_alarm_controller

Overview:
- Consumes the percent thresholds from the threshold programmer (high_threshold, low_threshold, 0..100) and a periodic level sample, also in percent.
- Drives the fill pump with hysteresis: start below the low threshold, stop at the high threshold.
- Raises the overflow alarm, underflow indication and a fault state.
- Every state change must be confirmed by consecutive samples, so a noisy sensor cannot cause chatter.

Parameters:
- CONFIRM_SAMPLES, 4: consecutive qualifying samples required before any non-fault transition; legal range 1..15.
- BLINK_CYCLES, 50_000_000: clock cycles per half-period of alarm_led blinking.
- LEVEL_MAX, 100: largest legal level or threshold value.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  single-cycle strobe; level is valid in this cycle
- level  in  8  measured level, percent
- high_threshold  in  8  from the threshold programmer
- low_threshold  in  8  from the threshold programmer
- pump_on  out  1  fill pump enable
- overflow_alarm  out  1  high-alarm state active
- underflow  out  1  low/filling state active
- fault  out  1  fault state active
- alarm_led  out  1  blinks in HIGH or FAULT, 0 otherwise
- state  out  2  0=NORMAL, 1=LOW, 2=HIGH, 3=FAULT

Behaviour:
- Reset, sampled on a clk_100MHz edge: state=NORMAL, all outputs 0, confirm counter 0, candidate target cleared, blink counter 0.
- All outputs are registered and decoded from the state register:
  - pump_on = (state==LOW)
  - underflow = (state==LOW)
  - overflow_alarm = (state==HIGH)
  - fault = (state==FAULT)
- Input validity:
  - A sample is bad if level > LEVEL_MAX, high_threshold > LEVEL_MAX, or high_threshold <= low_threshold.
  - Thresholds are checked only when sample_valid=1.
- The state machine advances only in cycles with sample_valid=1; other cycles hold state and counter.
- A bad sample forces FAULT in the next cycle from any state, with no confirmation, and clears the counter.
- Transition conditions, evaluated per valid, good sample:
  - NORMAL -> LOW: level <= low_threshold.
  - NORMAL -> HIGH: level > high_threshold.
  - LOW -> NORMAL: level >= high_threshold.
  - HIGH -> NORMAL: level < high_threshold.
  - FAULT -> NORMAL: any good sample.
- Confirm counter:
  - Increments on each valid sample meeting the pending transition's condition.
  - Clears to 0 on any valid sample that does not meet it.
  - In NORMAL, a candidate register holds the target (LOW or HIGH). A qualifying sample for a different target than the candidate restarts the counter at 1 with the new candidate.
  - When the counter would reach CONFIRM_SAMPLES, the state updates at the same clock edge and the counter clears.
  - Latency: the state changes one cycle after the sample_valid strobe of the Nth qualifying sample.
- Counter width is 4 bits and saturates at CONFIRM_SAMPLES; it never wraps.
- CONFIRM_SAMPLES=1 means every qualifying good sample transitions immediately on the next edge.
- Threshold changes while in LOW or HIGH take effect on the next valid sample; the counter is not cleared by the change itself.
- Blink counter:
  - Runs only in HIGH or FAULT.
  - Toggles alarm_led on reaching BLINK_CYCLES-1, then wraps to 0.
  - First toggle to 1 occurs BLINK_CYCLES cycles after entering the state.
  - Leaving HIGH/FAULT clears the counter and alarm_led in the same edge as the state change.
- Reset asserted mid-confirmation or mid-blink returns everything to reset values on that edge.
- Arithmetic: unsigned 8-bit compares only; no sign extension; thresholds are not latched.

Test Plan (CONFIRM_SAMPLES=4, BLINK_CYCLES=8, thresholds high=75, low=25 unless noted):
- Reset, then 4 valid samples of level=20 -> state=LOW and pump_on=1 one cycle after the 4th strobe. After only 3 samples, state is still NORMAL.
- In LOW, samples 50,50,76,76,76,40,76,76,76,76 -> pump_on stays 1 until one cycle after the last 76 (the 40 resets the count), then state=NORMAL and pump_on=0.
- From NORMAL, 4 samples of level=90 -> state=HIGH, overflow_alarm=1, alarm_led rises after 8 cycles and toggles every 8 cycles. Then 4 samples of level=70 -> NORMAL with alarm_led=0.
- From NORMAL, samples 20,20,90,20 -> no transition (candidate switch restarts the count). Then 20,20,20 -> LOW after the 3rd.
- A single sample level=120, or thresholds high=30/low=30 -> FAULT next cycle from any state, fault=1, pump_on=0. Then 4 good samples of level=50 -> NORMAL.
- Assert reset for 1 cycle while in LOW with counter=2 -> all outputs 0 and state=NORMAL on that edge; the next 3 samples at level=20 do not reach LOW.
